// File: rtl/pixel_write_buffer_if.sv
// pixel_write_buffer_if: pixel input handshake plus SDRAM bridge write port
interface pixel_write_buffer_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [9:0]        x_in;
    logic [9:0]        y_in;
    logic [DATA_W-1:0] intensity_in;
    logic [ADDR_W-1:0] bridge_address;
    logic              bridge_write;
    logic [DATA_W-1:0] bridge_write_data;
    logic              bridge_ack;
    modport master (
        output in_valid, x_in, y_in, intensity_in, bridge_ack,
        input  in_ready, bridge_address, bridge_write, bridge_write_data
    );
    modport slave (
        input  in_valid, x_in, y_in, intensity_in, bridge_ack,
        output in_ready, bridge_address, bridge_write, bridge_write_data
    );
endinterface

// File: rtl/pixel_write_buffer.sv
// pixel_write_buffer: maps pixels to SDRAM word addresses, queues them in a FIFO and issues acked bridge writes
module pixel_write_buffer #(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = 23,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    pixel_write_buffer_if.slave    bus,
    input  logic                   frame_clear,
    output logic                   idle,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic [18:0]            pixel_count,
    output logic                   drop_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic {IDLE, WRITE} state_t;
    state_t            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [18:0]       pix_q, pix_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] push_addr;
    logic              ready, in_range, accept, push, pop, acked;

    always_comb begin
        push_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(bus.y_in) * ADDR_W'(H_RES) + ADDR_W'(bus.x_in);
        in_range  = (32'(bus.x_in) < 32'(H_RES)) && (32'(bus.y_in) < 32'(V_RES));
        ready     = count_q < CW'(DEPTH);
        accept    = bus.in_valid && ready;
        push      = accept && in_range;
        acked     = (state_q == WRITE) && bus.bridge_ack;
        // the head leaves the FIFO whenever the bridge port is free or frees up this edge
        pop       = (count_q != '0) && ((state_q == IDLE) || acked);
        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        count_d   = count_q + CW'(push) - CW'(pop);
        addr_d    = pop ? addr_mem[rd_ptr_q] : addr_q;
        data_d    = pop ? data_mem[rd_ptr_q] : data_q;
        state_d   = pop ? WRITE : (acked ? IDLE : state_q);
        pix_d     = frame_clear ? '0 : ((acked && pix_q != '1) ? pix_q + 19'd1 : pix_q);
        drop_d    = frame_clear ? 1'b0 : (drop_q || (accept && !in_range));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            pix_q    <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            pix_q    <= pix_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= push_addr;
            data_mem[wr_ptr_q] <= bus.intensity_in;
        end
    end

    assign bus.in_ready          = ready;
    assign bus.bridge_address    = addr_q;
    assign bus.bridge_write_data = data_q;
    assign bus.bridge_write      = state_q == WRITE;
    assign idle                  = (count_q == '0) && (state_q == IDLE);
    assign fill_level            = count_q;
    assign pixel_count           = pix_q;
    assign drop_err              = drop_q;
endmodule

// File: tb/tb_pixel_write_buffer.sv
// tb_pixel_write_buffer: directed + random stimulus checked every cycle against a queue-based model
module tb_pixel_write_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_clear = 1'b0;
    logic        idle, drop_err;
    logic [4:0]  fill_level;
    logic [18:0] pixel_count;
    int          total = 0;
    int          bad = 0;

    pixel_write_buffer_if #(.ADDR_W(23), .DATA_W(8)) bus ();

    pixel_write_buffer dut (
        .CLK(clk), .RESET(rst), .bus(bus), .frame_clear(frame_clear),
        .idle(idle), .fill_level(fill_level), .pixel_count(pixel_count), .drop_err(drop_err)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: pixels waiting in the buffer, plus the write currently offered to the bridge
    logic [30:0] mq[$];
    logic        m_ok = 1'b0;
    logic        m_cur = 1'b0;
    logic [22:0] m_addr = '0;
    logic [7:0]  m_data = '0;
    int          m_pix = 0;
    logic        m_drop = 1'b0;
    int          m_acc = 0;

    always @(negedge clk) begin
        logic acc, ackt, rng;
        if (m_ok) begin
            chk("bridge_write", bus.bridge_write, m_cur);
            if (m_cur) begin
                chk("bridge_address", bus.bridge_address, m_addr);
                chk("bridge_write_data", bus.bridge_write_data, m_data);
            end
            chk("fill_level", fill_level, mq.size());
            chk("in_ready", bus.in_ready, mq.size() < 16);
            chk("idle", idle, mq.size() == 0 && !m_cur);
            chk("pixel_count", pixel_count, m_pix);
            chk("drop_err", drop_err, m_drop);
        end
        if (rst) begin
            mq.delete();
            m_cur = 1'b0; m_addr = '0; m_data = '0; m_pix = 0; m_drop = 1'b0; m_acc = 0; m_ok = 1'b1;
        end else if (m_ok) begin
            acc  = bus.in_valid && mq.size() < 16;
            ackt = m_cur && bus.bridge_ack;
            rng  = bus.x_in < 640 && bus.y_in < 480;
            m_pix  = frame_clear ? 0 : ((ackt && m_pix != 524287) ? m_pix + 1 : m_pix);
            m_drop = frame_clear ? 1'b0 : (m_drop || (acc && !rng));
            if ((!m_cur || ackt) && mq.size() > 0) begin
                {m_addr, m_data} = mq.pop_front();
                m_cur = 1'b1;
            end else if (ackt) m_cur = 1'b0;
            if (acc && rng) begin
                mq.push_back({23'(int'(bus.y_in) * 640 + int'(bus.x_in)), bus.intensity_in});
                m_acc++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int x, input int y, input logic [7:0] i);
        bus.in_valid = v;
        bus.x_in = 10'(x);
        bus.y_in = 10'(y);
        bus.intensity_in = i;
    endtask

    initial begin
        int a0;
        drive(0, 0, 0, 0);
        bus.bridge_ack = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        chk("rst_fill", fill_level, 0);
        chk("rst_idle", idle, 1);
        chk("rst_ready", bus.in_ready, 1);

        drive(1, 3, 2, 8'h5A); cyc();
        drive(0, 0, 0, 0); cyc();
        chk("t1_write", bus.bridge_write, 1);
        chk("t1_addr", bus.bridge_address, 1283);
        chk("t1_data", bus.bridge_write_data, 8'h5A);
        repeat (3) cyc();
        chk("t1_hold_addr", bus.bridge_address, 1283);
        bus.bridge_ack = 1'b1; cyc();
        bus.bridge_ack = 1'b0;
        chk("t1_done_write", bus.bridge_write, 0);
        chk("t1_count", pixel_count, 1);
        chk("t1_idle", idle, 1);

        a0 = m_acc;
        for (int i = 0; i < 20; i++) begin
            drive(1, i, 10, 8'(i + 1)); cyc();
        end
        drive(0, 0, 0, 0);
        chk("t2_accepted", m_acc - a0, 17);
        chk("t2_fill", fill_level, 16);
        chk("t2_ready", bus.in_ready, 0);
        chk("t2_write", bus.bridge_write, 1);
        chk("t2_head_addr", bus.bridge_address, 6400);

        frame_clear = 1'b1; cyc();
        frame_clear = 1'b0;
        bus.bridge_ack = 1'b1;
        repeat (16) cyc();
        chk("t3_count16", pixel_count, 16);
        chk("t3_fill", fill_level, 0);
        chk("t3_last_addr", bus.bridge_address, 6416);
        cyc();
        bus.bridge_ack = 1'b0;
        chk("t3_count17", pixel_count, 17);
        chk("t3_idle", idle, 1);

        drive(1, 640, 0, 8'h11); cyc();
        drive(0, 0, 0, 0); cyc();
        chk("t4_drop", drop_err, 1);
        chk("t4_no_write", bus.bridge_write, 0);
        chk("t4_fill", fill_level, 0);
        frame_clear = 1'b1; cyc();
        frame_clear = 1'b0;
        chk("t4_drop_clr", drop_err, 0);
        chk("t4_count_clr", pixel_count, 0);

        drive(1, 1, 1, 8'hA1); cyc();
        drive(1, 2, 1, 8'hA2); cyc();
        chk("t5_fill_pre", fill_level, 1);
        drive(1, 3, 1, 8'hA3);
        bus.bridge_ack = 1'b1; cyc();
        drive(0, 0, 0, 0);
        bus.bridge_ack = 1'b0;
        chk("t5_fill_same", fill_level, 1);
        chk("t5_addr", bus.bridge_address, 642);

        for (int k = 0; k < 150; k++) begin
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 659), $urandom_range(0, 489), 8'($urandom));
            bus.bridge_ack = 1'($urandom_range(0, 1));
            cyc();
        end
        drive(0, 0, 0, 0);
        bus.bridge_ack = 1'b1;
        for (int k = 0; k < 100 && !idle; k++) cyc();
        bus.bridge_ack = 1'b0;
        chk("drain_idle", idle, 1);

        for (int i = 0; i < 6; i++) begin
            drive(1, i, 5, 8'(i)); cyc();
        end
        drive(0, 0, 0, 0);
        chk("t6_fill5", fill_level, 5);
        chk("t6_write", bus.bridge_write, 1);
        rst = 1'b1; cyc();
        rst = 1'b0;
        chk("t6_write_off", bus.bridge_write, 0);
        chk("t6_fill", fill_level, 0);
        chk("t6_idle", idle, 1);
        chk("t6_count", pixel_count, 0);
        repeat (2) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
